register_file: RTL and testbench

Architectural register file and condition-flag register of the 16-bit CPU. It sits directly upstream and downstream of the 16-bit ALU built from ALU1 slices. The two read ports drive the ALU A and B operand buses. The write port and the flag inputs capture the ALU Result and status on the clock edge that retires the instruction. Register R0 is hardwired to zero, which keeps the ALU's subtract/Less (set-on-less-than) path usable for compare-and-discard.

---
 rtl/register_file.sv | 82 ++++++++
 tb/tb_register_file.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: architectural register file and condition-flag register
// of the 16-bit CPU, between the ALU result bus and its operand buses.
//
// Ports:
//   Clock, Reset      - single clock; synchronous active-high reset
//   RegA, RegB        - read addresses for operand ports A and B
//   DataA, DataB      - combinational read data (R0 always reads zero)
//   RegW, WE          - write address and write enable
//   WriteData         - value written, normally the ALU Result
//   FlagWE            - load enable for the flag register
//   CarryIn           - ALU carry out of the most-significant slice
//   OverflowIn        - ALU signed overflow
//   Zero, Negative    - registered zero/sign of WriteData at last flag load
//   Carry, Overflow   - registered CarryIn/OverflowIn at last flag load
module register_file #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [ADDR-1:0]  RegA,
    input  logic [ADDR-1:0]  RegB,
    output logic [WIDTH-1:0] DataA,
    output logic [WIDTH-1:0] DataB,
    input  logic [ADDR-1:0]  RegW,
    input  logic             WE,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             FlagWE,
    input  logic             CarryIn,
    input  logic             OverflowIn,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int NREG = 1 << ADDR;

    // Only R1..R(NREG-1) are storage; R0 is a constant zero.
    logic [WIDTH-1:0] regs [1:NREG-1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            // Address 0 never matches a stored entry, so R0 writes vanish.
            for (int i = 1; i < NREG; i++) begin
                if (WE && RegW == ADDR'(i)) begin
                    regs[i] <= WriteData;
                end
            end
            // Flags come from WriteData, so compares into R0 still set them.
            if (FlagWE) begin
                Zero     <= (WriteData == '0);
                Negative <= WriteData[WIDTH-1];
                Carry    <= CarryIn;
                Overflow <= OverflowIn;
            end
        end
    end

    // No write bypass: reads see state as of the last edge.
    always_comb begin
        DataA = '0;
        DataB = '0;
        for (int i = 1; i < NREG; i++) begin
            if (RegA == ADDR'(i)) begin
                DataA = regs[i];
            end
            if (RegB == ADDR'(i)) begin
                DataB = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed bench for register_file with a scoreboard
// queue of expected values checked by immediate assertions.
module tb_register_file;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  RegA, RegB, RegW;
    logic [15:0] DataA, DataB;
    logic        WE, FlagWE, CarryIn, OverflowIn;
    logic [15:0] WriteData;
    logic        Zero, Negative, Carry, Overflow;

    int passed = 0;
    int total  = 0;

    string       tag_q [$];
    logic [15:0] exp_q [$];

    register_file #(.WIDTH(16), .ADDR(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .RegA(RegA), .RegB(RegB),
        .DataA(DataA), .DataB(DataB),
        .RegW(RegW), .WE(WE), .WriteData(WriteData),
        .FlagWE(FlagWE), .CarryIn(CarryIn), .OverflowIn(OverflowIn),
        .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] flags();
        return {12'h000, Zero, Negative, Carry, Overflow};
    endfunction

    task automatic push(input string t, input logic [15:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: got %h required entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s: got %h required %h", t, obs, e);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; RegA = 0; RegB = 0; RegW = 0;
        WE = 0; FlagWE = 0; CarryIn = 0; OverflowIn = 0;
        WriteData = 16'h0000;
        #2;
        step();
        Reset = 1'b0;

        // Reset state on every address, both ports
        for (int a = 0; a < 4; a++) begin
            RegA = 2'(a); RegB = 2'(3 - a);
            #1;
            push($sformatf("rst_A%0d", a), 16'h0000); check(DataA);
            push($sformatf("rst_B%0d", 3 - a), 16'h0000); check(DataB);
        end
        push("rst_flags", 16'h0000); check(flags());

        // Write R2, no bypass before the edge
        WE = 1; RegW = 2; WriteData = 16'hA5C3; RegA = 2;
        #1;
        push("no_bypass", 16'h0000); check(DataA);
        step();
        push("wr_r2", 16'hA5C3); check(DataA);

        // R0 write discarded, flags still load from WriteData
        WE = 1; RegW = 0; WriteData = 16'hFFFF; FlagWE = 1;
        CarryIn = 0; OverflowIn = 0;
        step();
        WE = 0; FlagWE = 0; RegA = 0; RegB = 2;
        #1;
        push("r0_zero", 16'h0000); check(DataA);
        push("r0_keep_r2", 16'hA5C3); check(DataB);
        push("r0_flags", 16'h0004); check(flags());

        // Flag load without write: Z=1 C=1
        WriteData = 16'h0000; FlagWE = 1; CarryIn = 1; OverflowIn = 0;
        step();
        push("flag_zc", 16'h000A); check(flags());
        FlagWE = 0; WriteData = 16'h8000; CarryIn = 0; OverflowIn = 1;
        step();
        push("flag_hold", 16'h000A); check(flags());
        FlagWE = 1; WriteData = 16'h0001; CarryIn = 0; OverflowIn = 1;
        step();
        push("flag_ov", 16'h0001); check(flags());
        FlagWE = 0;

        // Dual port
        WE = 1; RegW = 1; WriteData = 16'h1234;
        step();
        RegW = 3; WriteData = 16'h8001;
        step();
        WE = 0; RegA = 1; RegB = 3;
        #1;
        push("dual_A", 16'h1234); check(DataA);
        push("dual_B", 16'h8001); check(DataB);
        RegA = 3;
        #1;
        push("same_A", 16'h8001); check(DataA);
        push("same_B", 16'h8001); check(DataB);
        push("dual_flags_hold", 16'h0001); check(flags());

        // WE=0 holds registers
        RegW = 2; WriteData = 16'hBEEF;
        step();
        RegA = 2;
        #1;
        push("we0_hold", 16'hA5C3); check(DataA);

        // Back-to-back writes, last edge wins
        WE = 1; RegW = 3; WriteData = 16'h1111;
        step();
        WriteData = 16'h2222;
        step();
        WE = 0; RegA = 3;
        #1;
        push("b2b_last", 16'h2222); check(DataA);

        // Reset priority over WE and FlagWE
        WE = 1; RegW = 1; WriteData = 16'h00FF;
        step();
        WE = 0; RegA = 1;
        #1;
        push("pre_rst_r1", 16'h00FF); check(DataA);
        Reset = 1; WE = 1; RegW = 1; WriteData = 16'h7777;
        FlagWE = 1; CarryIn = 1; OverflowIn = 1;
        step();
        Reset = 0; WE = 0; FlagWE = 0;
        RegA = 1; RegB = 2;
        #1;
        push("rstp_r1", 16'h0000); check(DataA);
        push("rstp_r2", 16'h0000); check(DataB);
        RegA = 3;
        #1;
        push("rstp_r3", 16'h0000); check(DataA);
        push("rstp_flags", 16'h0000); check(flags());
        step();
        RegA = 1;
        #1;
        push("post_rst_idle", 16'h0000); check(DataA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
